circuito_jogo: RTL and testbench

- Top-level controller for two-player "ultimate" tic-tac-toe: nine macro boards of 3x3 micro cells, with moves entered on nine one-hot buttons.
- Contains an FSM, a move register, 81x2-bit cell memory, 9x2-bit macro-status memory, and line-win detection.
- Drives the game LEDs plus a 7-segment debug bank.

---
 rtl/circuito_jogo.sv | 190 +++++++++++++++++++
 tb/tb_circuito_jogo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/circuito_jogo.sv
// Ultimate tic-tac-toe controller: nine 3x3 macro boards, one-hot move buttons,
// move/turn FSM, line-win detection and a 7-segment debug bank.
module circuito_jogo (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [8:0] botoes,
  output logic [8:0] leds,
  output logic       pronto,
  output logic       db_tem_jogada,
  output logic       jogar_macro,
  output logic       jogar_micro,
  output logic [6:0] db_macro,
  output logic [6:0] db_micro,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogador,
  output logic [6:0] db_J
);

  typedef enum logic [3:0] {
    StInicial       = 4'h0,
    StPreparacao    = 4'h1,
    StEsperaMacro   = 4'h2,
    StValidaMacro   = 4'h3,
    StEsperaMicro   = 4'h4,
    StValidaMicro   = 4'h5,
    StEscreve       = 4'h6,
    StVerificaMacro = 4'h7,
    StVerificaFim   = 4'h8,
    StTrocaJogador  = 4'h9,
    StFim           = 4'hF
  } estado_e;

  // Cell/status codes: 0 empty/open, 1 player 1, 2 player 2, 3 full (status only)
  estado_e               estado_q, estado_d;
  logic                  tem_q;
  logic                  jogada;
  logic [3:0]            idx_enc, idx_q;
  logic [1:0]            jogador_q, vencedor_q;
  logic [3:0]            macro_q, micro_q;
  logic [3:0]            macro_idx, micro_idx;
  logic [8:0][8:0][1:0]  cells_q;
  logic [8:0][1:0]       status_q;
  logic [8:0]            owned_cells, filled_cells, owned_macros, abertos;

  function automatic logic has_line(input logic [8:0] m);
    has_line = (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
               (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] on;
    case (v)
      4'h0:    on = 7'h3F;
      4'h1:    on = 7'h06;
      4'h2:    on = 7'h5B;
      4'h3:    on = 7'h4F;
      4'h4:    on = 7'h66;
      4'h5:    on = 7'h6D;
      4'h6:    on = 7'h7D;
      4'h7:    on = 7'h07;
      4'h8:    on = 7'h7F;
      4'h9:    on = 7'h6F;
      4'hA:    on = 7'h77;
      4'hB:    on = 7'h7C;
      4'hC:    on = 7'h39;
      4'hD:    on = 7'h5E;
      4'hE:    on = 7'h79;
      default: on = 7'h71;
    endcase
    hex7 = ~on;
  endfunction

  assign db_tem_jogada = |botoes;
  assign jogada        = db_tem_jogada & ~tem_q;
  assign macro_idx     = macro_q - 4'd1;
  assign micro_idx     = micro_q - 4'd1;

  // Lowest set button wins
  always_comb begin
    idx_enc = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (botoes[i]) idx_enc = 4'(i);
    end
  end

  always_comb begin
    owned_cells  = '0;
    filled_cells = '0;
    owned_macros = '0;
    abertos      = '0;
    for (int k = 0; k < 9; k++) begin
      owned_cells[k]  = (cells_q[macro_idx][k] == jogador_q);
      filled_cells[k] = (cells_q[macro_idx][k] != 2'd0);
      owned_macros[k] = (status_q[k] == jogador_q);
      abertos[k]      = (status_q[k] == 2'd0);
    end
  end

  always_comb begin
    estado_d    = estado_q;
    leds        = '0;
    pronto      = 1'b0;
    jogar_macro = 1'b0;
    jogar_micro = 1'b0;
    case (estado_q)
      StInicial:     if (iniciar) estado_d = StPreparacao;
      StPreparacao:  estado_d = StEsperaMacro;
      StEsperaMacro: begin
        jogar_macro = 1'b1;
        leds        = abertos;
        if (jogada) estado_d = StValidaMacro;
      end
      StValidaMacro: estado_d = abertos[idx_q] ? StEsperaMicro : StEsperaMacro;
      StEsperaMicro: begin
        jogar_micro = 1'b1;
        leds        = 9'd1 << macro_idx;
        if (jogada) estado_d = StValidaMicro;
      end
      StValidaMicro: begin
        estado_d = (cells_q[macro_idx][idx_q] == 2'd0) ? StEscreve : StEsperaMicro;
      end
      StEscreve:       estado_d = StVerificaMacro;
      StVerificaMacro: estado_d = StVerificaFim;
      StVerificaFim: begin
        if (has_line(owned_macros) || (abertos == 9'd0)) estado_d = StFim;
        else estado_d = StTrocaJogador;
      end
      StTrocaJogador: estado_d = abertos[micro_idx] ? StEsperaMicro : StEsperaMacro;
      StFim: begin
        pronto = 1'b1;
        if (iniciar) estado_d = StPreparacao;
      end
      default: estado_d = StInicial;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= StInicial;
      tem_q      <= 1'b0;
      idx_q      <= 4'd0;
      jogador_q  <= 2'd1;
      vencedor_q <= 2'd0;
      macro_q    <= 4'd0;
      micro_q    <= 4'd0;
    end else begin
      estado_q <= estado_d;
      tem_q    <= db_tem_jogada;
      // Only edges seen in a wait state count; others are consumed and dropped
      if (jogada && (estado_q == StEsperaMacro || estado_q == StEsperaMicro)) begin
        idx_q <= idx_enc;
      end
      case (estado_q)
        StPreparacao: begin
          cells_q    <= '0;
          status_q   <= '0;
          jogador_q  <= 2'd1;
          vencedor_q <= 2'd0;
          macro_q    <= 4'd0;
          micro_q    <= 4'd0;
        end
        StValidaMacro: if (abertos[idx_q]) macro_q <= idx_q + 4'd1;
        StEscreve: begin
          cells_q[macro_idx][idx_q] <= jogador_q;
          micro_q                   <= idx_q + 4'd1;
        end
        StVerificaMacro: begin
          if (has_line(owned_cells)) status_q[macro_idx] <= jogador_q;
          else if (&filled_cells)    status_q[macro_idx] <= 2'd3;
        end
        StVerificaFim: if (has_line(owned_macros)) vencedor_q <= jogador_q;
        StTrocaJogador: begin
          jogador_q <= (jogador_q == 2'd1) ? 2'd2 : 2'd1;
          macro_q   <= abertos[micro_idx] ? micro_q : 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign db_macro   = hex7(macro_q);
  assign db_micro   = hex7(micro_q);
  assign db_estado  = hex7(estado_q);
  assign db_jogador = (estado_q == StFim) ? hex7({2'b00, vencedor_q}) : hex7({2'b00, jogador_q});
  assign db_J       = 7'b1100001;

endmodule

// File: tb/tb_circuito_jogo.sv
// Directed bench for circuito_jogo: walks a scripted ultimate tic-tac-toe game.
module tb_circuito_jogo;

  logic       clock = 1'b0;
  logic       reset, iniciar;
  logic [8:0] botoes;
  logic [8:0] leds;
  logic       pronto, db_tem_jogada, jogar_macro, jogar_micro;
  logic [6:0] db_macro, db_micro, db_estado, db_jogador, db_J;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S9 = 7'h10, SF = 7'h0E, SJ = 7'h61;

  circuito_jogo dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .botoes        (botoes),
    .leds          (leds),
    .pronto        (pronto),
    .db_tem_jogada (db_tem_jogada),
    .jogar_macro   (jogar_macro),
    .jogar_micro   (jogar_micro),
    .db_macro      (db_macro),
    .db_micro      (db_micro),
    .db_estado     (db_estado),
    .db_jogador    (db_jogador),
    .db_J          (db_J)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One press: a single-cycle edge, then enough clocks to settle in a wait state
  task automatic move(input logic [8:0] b);
    botoes = b;
    tick();
    botoes = 9'h000;
    repeat (7) tick();
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; botoes = 9'h000;
    tick(); tick();
    check("rst_estado", db_estado, S0);
    check("rst_pronto", pronto, 1'b0);
    check("rst_jmacro", jogar_macro, 1'b0);
    check("rst_jmicro", jogar_micro, 1'b0);
    check("rst_leds", leds, 9'h000);
    check("rst_jogador", db_jogador, S1);
    check("rst_macro", db_macro, S0);
    check("rst_micro", db_micro, S0);
    check("db_J", db_J, SJ);
    check("rst_tem", db_tem_jogada, 1'b0);
    reset = 1'b0;

    iniciar = 1'b1;
    tick();
    check("ini_prep", db_estado, S1);
    tick();
    check("ini_espera", db_estado, S2);
    repeat (3) tick();
    iniciar = 1'b0;
    tick();
    check("ini_hold_state", db_estado, S2);
    check("ini_jmacro", jogar_macro, 1'b1);
    check("ini_leds", leds, 9'h1FF);
    check("ini_jogador", db_jogador, S1);

    move(9'h010);
    check("m5_estado", db_estado, S4);
    check("m5_jmicro", jogar_micro, 1'b1);
    check("m5_leds", leds, 9'h010);
    check("m5_macro", db_macro, S5);
    move(9'h001);
    check("p1_jogador", db_jogador, S2);
    check("p1_macro", db_macro, S1);
    check("p1_jmicro", jogar_micro, 1'b1);
    check("p1_leds", leds, 9'h001);

    move(9'h010);  // P2 micro 5 in macro 1
    move(9'h002);  // P1 micro 2 in macro 5
    move(9'h010);  // P2 micro 5 in macro 2
    move(9'h004);  // P1 micro 3 in macro 5, wins it
    check("won5_leds", leds, 9'h004);
    check("won5_macro", db_macro, S3);
    check("won5_micro", db_micro, S3);
    check("won5_jogador", db_jogador, S2);

    move(9'h010);  // P2 micro 5 in macro 3 -> macro 5 closed
    check("free_estado", db_estado, S2);
    check("free_jmacro", jogar_macro, 1'b1);
    check("free_leds", leds, 9'h1EF);
    check("free_jogador", db_jogador, S1);
    check("free_macro", db_macro, S0);

    move(9'h010);
    check("rej_macro_estado", db_estado, S2);
    check("rej_macro_jogador", db_jogador, S1);
    check("rej_macro_leds", leds, 9'h1EF);
    move(9'h001);
    check("pick1_estado", db_estado, S4);
    check("pick1_leds", leds, 9'h001);
    check("pick1_macro", db_macro, S1);
    move(9'h010);
    check("rej_micro_estado", db_estado, S4);
    check("rej_micro_jogador", db_jogador, S1);
    check("rej_micro_micro", db_micro, S5);
    move(9'h001);
    check("acc_jogador", db_jogador, S2);
    check("acc_micro", db_micro, S1);

    // Held button in macro 1: exactly one move
    botoes = 9'h002;
    repeat (20) tick();
    check("hold_tem", db_tem_jogada, 1'b1);
    botoes = 9'h000;
    repeat (3) tick();
    check("hold_estado", db_estado, S4);
    check("hold_jogador", db_jogador, S1);
    check("hold_macro", db_macro, S2);
    check("hold_micro", db_micro, S2);

    iniciar = 1'b1;
    repeat (2) tick();
    iniciar = 1'b0;
    tick();
    check("play_iniciar", db_estado, S4);

    // P1 takes macros 4 and 6 (bottom rows) for a middle-row win alongside macro 5
    move(9'h040); move(9'h008); move(9'h040); move(9'h020);
    move(9'h080); move(9'h008); move(9'h080); move(9'h020);
    move(9'h100); move(9'h008); move(9'h100);
    check("pre_win_macro", db_macro, S9);
    check("pre_win_jogador", db_jogador, S2);
    move(9'h020); move(9'h040);
    check("fim_estado", db_estado, SF);
    check("fim_pronto", pronto, 1'b1);
    check("fim_vencedor", db_jogador, S1);
    check("fim_leds", leds, 9'h000);
    check("fim_jmacro", jogar_macro, 1'b0);

    iniciar = 1'b1;
    tick(); tick();
    iniciar = 1'b0;
    tick();
    check("new_estado", db_estado, S2);
    check("new_pronto", pronto, 1'b0);
    check("new_leds", leds, 9'h1FF);
    check("new_jogador", db_jogador, S1);
    check("new_micro", db_micro, S0);
    move(9'h001);
    move(9'h010);  // cell previously held by P2 must now be free
    check("new_cleared", db_jogador, S2);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("final_rst", db_estado, S0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
